// File: rtl/agc_io_uart_tx.sv
// agc_io_uart_tx: passive snooper of the Core IO write bus. Qualifying writes
// ({sel, data}) are queued in a small FIFO and sent as 3-byte UART packets:
//   B0 = {3'b101, sel}, B1 = {1'b0, data[14:8]}, B2 = data[7:0]
// Framing is 8N1. Defining AGC_UART_TX_PARITY_EN inserts an even-parity bit
// after data bit 7 of every byte, giving 11-bit frames.
module agc_io_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] SEL_MASK     = 32'hFFFF_FFFF
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          io_write_en,
  input  logic [4:0]                    io_write_sel,
  input  logic [14:0]                   io_write_data,
  input  logic                          overflow_clr,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRELAST = CW'(CLKS_PER_BIT - 2);
  localparam logic [AW:0]   DEPTH_CNT   = (AW+1)'(FIFO_DEPTH);

`ifdef AGC_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_STOP   = 3'd4,
    ST_PARITY = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`endif

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

  // Byte k of the packet built from a queued {sel, data} entry.
  function automatic logic [7:0] packet_byte(input logic [19:0] e, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = {3'b101, e[19:15]};
      2'd1:    b = {1'b0, e[14:8]};
      default: b = e[7:0];
    endcase
    return b;
  endfunction

  // FIFO storage and bookkeeping
  logic [19:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_d;
  logic          r_ovf;
  logic          w_push_req;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;

  // Serializer state
  state_t        r_state;
  state_t        w_state_d;
  logic [CW-1:0] r_clk_cnt;
  logic [CW-1:0] w_clk_cnt_d;
  logic [2:0]    r_bit_idx;
  logic [2:0]    w_bit_idx_d;
  logic [1:0]    r_byte_idx;
  logic [1:0]    w_byte_idx_d;
  logic [19:0]   r_entry;
  logic [19:0]   w_entry_d;
  logic [7:0]    w_cur_byte;
  logic          w_bit_done;
  logic          r_tx;
  logic          w_tx_d;
  logic          r_busy;

  assign w_bit_done = (r_clk_cnt == CNT_LAST);
  assign w_cur_byte = packet_byte(r_entry, r_byte_idx);

  // FIFO push/pop/drop qualification and next occupancy.
  always_comb begin
    w_push_req = io_write_en & SEL_MASK[io_write_sel];
    w_full     = (r_count == DEPTH_CNT);
    w_empty    = (r_count == '0);
    w_pop      = (r_state == ST_LOAD);
    w_push     = w_push_req & (~w_full | w_pop);
    w_drop     = w_push_req & w_full & ~w_pop;
    case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + (AW+1)'(1);
      2'b01:   w_count_d = r_count - (AW+1)'(1);
      default: w_count_d = r_count;
    endcase
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_d;
      if (w_drop)            r_ovf <= 1'b1;
      else if (overflow_clr) r_ovf <= 1'b0;
      else                   r_ovf <= r_ovf;
    end
  end

  // FIFO storage write; contents are meaningless unless counted.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= {io_write_sel, io_write_data};
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_d;
  end

  // FSM next state; STOP of the last byte hands over to LOAD one cycle early
  // so that queued packets follow each other with no idle gap.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE:  if (!w_empty) w_state_d = ST_LOAD; else w_state_d = ST_IDLE;
      ST_LOAD:  w_state_d = ST_START;
      ST_START: if (w_bit_done) w_state_d = ST_DATA; else w_state_d = ST_START;
      ST_DATA: begin
        if (w_bit_done && (r_bit_idx == 3'd7)) begin
`ifdef AGC_UART_TX_PARITY_EN
          w_state_d = ST_PARITY;
`else
          w_state_d = ST_STOP;
`endif
        end else begin
          w_state_d = ST_DATA;
        end
      end
`ifdef AGC_UART_TX_PARITY_EN
      ST_PARITY: if (w_bit_done) w_state_d = ST_STOP; else w_state_d = ST_PARITY;
`endif
      ST_STOP: begin
        if (r_byte_idx < 2'd2) begin
          if (w_bit_done) w_state_d = ST_START; else w_state_d = ST_STOP;
        end else if (!w_empty && (r_clk_cnt == CNT_PRELAST)) begin
          w_state_d = ST_LOAD;
        end else if (w_bit_done) begin
          if (w_empty) w_state_d = ST_IDLE; else w_state_d = ST_LOAD;
        end else begin
          w_state_d = ST_STOP;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: bit timing, byte/bit indices and the next line level.
  always_comb begin
    w_clk_cnt_d  = '0;
    w_bit_idx_d  = 3'd0;
    w_byte_idx_d = r_byte_idx;
    w_entry_d    = r_entry;
    w_tx_d       = 1'b1;
    if ((w_state_d != r_state) || (r_state == ST_IDLE) || (r_state == ST_LOAD)) begin
      w_clk_cnt_d = '0;
    end else begin
      w_clk_cnt_d = r_clk_cnt + CW'(1);
    end
    if (r_state == ST_DATA) begin
      if (w_bit_done) w_bit_idx_d = r_bit_idx + 3'd1;
      else            w_bit_idx_d = r_bit_idx;
    end else begin
      w_bit_idx_d = 3'd0;
    end
    if (r_state == ST_LOAD) begin
      w_byte_idx_d = 2'd0;
      w_entry_d    = r_mem[r_rd_ptr];
    end else if ((r_state == ST_STOP) && (w_state_d == ST_START)) begin
      w_byte_idx_d = r_byte_idx + 2'd1;
    end else begin
      w_byte_idx_d = r_byte_idx;
    end
    case (w_state_d)
      ST_START:  w_tx_d = 1'b0;
      ST_DATA:   w_tx_d = w_cur_byte[w_bit_idx_d];
`ifdef AGC_UART_TX_PARITY_EN
      ST_PARITY: w_tx_d = even_parity(w_cur_byte);
`endif
      default:   w_tx_d = 1'b1;
    endcase
  end

  // Serializer datapath registers and glitch-free line/busy flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_cnt  <= '0;
      r_bit_idx  <= 3'd0;
      r_byte_idx <= 2'd0;
      r_entry    <= 20'd0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_clk_cnt  <= w_clk_cnt_d;
      r_bit_idx  <= w_bit_idx_d;
      r_byte_idx <= w_byte_idx_d;
      r_entry    <= w_entry_d;
      r_tx       <= w_tx_d;
      r_busy     <= (w_state_d != ST_IDLE) || (w_count_d != '0);
    end
  end

  assign uart_tx    = r_tx;
  assign tx_busy    = r_busy;
  assign overflow   = r_ovf;
  assign fifo_count = r_count;

endmodule
